// File: rtl/calcu_mailbox_ctrl.sv
// calcu_mailbox_ctrl
// Sequences one calculator request through a mailbox in data memory:
// writes op_a, op_b and opcode, raises the request flag, polls until the
// core posts the done flag (or the poll budget runs out), fetches the
// result and clears the flag.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 one-cycle request pulse, honoured only in IDLE
//   op_a, op_b, opcode    request operands, latched at an accepted start
//   busy                  request in flight
//   done / error          one-cycle completion / timeout pulses
//   result                last fetched result, held until the next done
//   EntradaCalcu          write data to the memory calculator port
//   addressCalcu          address to the memory calculator port
//   writeEnableCalcu      write strobe to the memory calculator port
//   resultadoCalcu        read data from the memory calculator port
//                         (combinational on addressCalcu)
module calcu_mailbox_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0040,
    parameter int          TIMEOUT   = 1024,
    parameter int          TW        = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [3:0]  opcode,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] result,
    output logic [31:0] EntradaCalcu,
    output logic [31:0] addressCalcu,
    output logic        writeEnableCalcu,
    input  logic [31:0] resultadoCalcu
);

    // Offsets wrap modulo 2^32 by plain 32-bit addition.
    localparam logic [31:0]   ADDR_A    = BASE_ADDR;
    localparam logic [31:0]   ADDR_B    = BASE_ADDR + 32'd4;
    localparam logic [31:0]   ADDR_OP   = BASE_ADDR + 32'd8;
    localparam logic [31:0]   ADDR_FLAG = BASE_ADDR + 32'd12;
    localparam logic [31:0]   ADDR_RES  = BASE_ADDR + 32'd16;
    localparam logic [TW-1:0] CNT_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_A, S_WR_B, S_WR_OP, S_WR_FLAG,
        S_POLL, S_RD_RES, S_CLR, S_ABORT
    } state_t;

    state_t        r_state, w_next;
    logic [31:0]   r_a, r_b;
    logic [3:0]    r_op;
    logic [TW-1:0] r_cnt;

    logic          r_busy, r_done, r_error, r_we;
    logic [31:0]   r_result, r_data, r_addr;

    logic          w_busy, w_done, w_error, w_we;
    logic [31:0]   w_data, w_addr;

    // Next-state logic works on the current state; POLL looks at the
    // flag word that the registered address already selects.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_WR_A;
            S_WR_A:    w_next = S_WR_B;
            S_WR_B:    w_next = S_WR_OP;
            S_WR_OP:   w_next = S_WR_FLAG;
            S_WR_FLAG: w_next = S_POLL;
            S_POLL: begin
                if (resultadoCalcu == 32'd2)  w_next = S_RD_RES;
                else if (r_cnt == CNT_LAST)   w_next = S_ABORT;
            end
            S_RD_RES:  w_next = S_CLR;
            S_CLR:     w_next = S_IDLE;
            S_ABORT:   w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered and registered,
    // so each state's memory access is on the port for that whole cycle.
    always_comb begin
        w_addr  = ADDR_FLAG;
        w_data  = 32'd0;
        w_we    = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_error = 1'b0;
        case (w_next)
            // WR_A is only entered from IDLE, before the latches load.
            S_WR_A:    begin w_addr = ADDR_A;  w_data = op_a; w_we = 1'b1; w_busy = 1'b1; end
            S_WR_B:    begin w_addr = ADDR_B;  w_data = r_b;  w_we = 1'b1; w_busy = 1'b1; end
            S_WR_OP:   begin w_addr = ADDR_OP; w_data = {28'd0, r_op}; w_we = 1'b1; w_busy = 1'b1; end
            S_WR_FLAG: begin w_data = 32'd1; w_we = 1'b1; w_busy = 1'b1; end
            S_POLL:    w_busy = 1'b1;
            S_RD_RES:  begin w_addr = ADDR_RES; w_busy = 1'b1; end
            S_CLR:     begin w_we = 1'b1; w_done = 1'b1; end
            S_ABORT:   begin w_we = 1'b1; w_error = 1'b1; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_op     <= 4'd0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_we     <= 1'b0;
            r_result <= 32'd0;
            r_data   <= 32'd0;
            r_addr   <= 32'd0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_error <= w_error;
            r_we    <= w_we;
            r_data  <= w_data;
            r_addr  <= w_addr;
            if (r_state == S_IDLE && start) begin
                r_a  <= op_a;
                r_b  <= op_b;
                r_op <= opcode;
            end
            if (r_state == S_WR_FLAG)
                r_cnt <= '0;
            else if (r_state == S_POLL && w_next == S_POLL)
                r_cnt <= r_cnt + TW'(1);
            if (r_state == S_RD_RES)
                r_result <= resultadoCalcu;
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign error            = r_error;
    assign result           = r_result;
    assign EntradaCalcu     = r_data;
    assign addressCalcu     = r_addr;
    assign writeEnableCalcu = r_we;

endmodule

// File: tb/tb_calcu_mailbox_ctrl.sv
// tb_calcu_mailbox_ctrl
// Two instances (mailbox at 0x40 and at 0xFFFF_FFF8, so the second one
// wraps) share one stimulus stream. Each has a mailbox memory with a fake
// core that posts the done flag a chosen number of polls after the
// request flag is written. The stimulus process predicts every memory
// write, done and error event (value and cycle) into per-instance queues;
// a negedge monitor pops and compares whatever the DUTs present.
module tb_calcu_mailbox_ctrl;

    localparam int          TO    = 16;
    localparam logic [31:0] BASE0 = 32'h0000_0040;
    localparam logic [31:0] BASE1 = 32'hFFFF_FFF8;

    typedef struct {
        int          kind;   // 0 write, 1 done, 2 error
        logic [31:0] addr;
        logic [31:0] data;   // write data, or result for done/error
        int          cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] op_a, op_b;
    logic [3:0]  opcode;
    logic        busy [2], done [2], err [2], we [2];
    logic [31:0] res [2], wdata [2], addr [2], rd [2];

    int  cyc = 0;
    int  nvec = 0, nerr = 0;
    int  cur_d = 0;
    logic [31:0] cur_res = 0;
    ev_t exp_q [2][$];
    int  busy_from = 0, busy_to = 0, last_end = -1;
    logic [31:0] prev_res = 0;
    bit  mon_en = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_i
        localparam logic [31:0] B = (g == 0) ? BASE0 : BASE1;
        logic [31:0] mb [5];
        logic [31:0] off;
        int pend = 0;

        calcu_mailbox_ctrl #(.BASE_ADDR(B), .TIMEOUT(TO), .TW(5)) dut (
            .clk(clk), .reset(reset), .start(start),
            .op_a(op_a), .op_b(op_b), .opcode(opcode),
            .busy(busy[g]), .done(done[g]), .error(err[g]), .result(res[g]),
            .EntradaCalcu(wdata[g]), .addressCalcu(addr[g]),
            .writeEnableCalcu(we[g]), .resultadoCalcu(rd[g]));

        assign off   = addr[g] - B;
        assign rd[g] = (off < 32'd20 && off[1:0] == 2'b00) ? mb[off >> 2] : 32'hDEAD_BEEF;

        // Fake core: after a request flag, shows garbage (3) while busy,
        // then posts result and flag=2 so it is seen on poll number cur_d.
        always @(posedge clk) begin
            if (we[g] && off < 32'd20 && off[1:0] == 2'b00) mb[off >> 2] <= wdata[g];
            if (reset) pend <= 0;
            else if (we[g] && off == 32'd12 && wdata[g] == 32'd1) begin
                if (cur_d == 0) begin mb[3] <= 32'd2; mb[4] <= cur_res; pend <= 0; end
                else pend <= cur_d;
            end else if (we[g] && off == 32'd12) pend <= 0;
            else if (pend > 0) begin
                pend <= pend - 1;
                if (pend == 1) begin mb[3] <= 32'd2; mb[4] <= cur_res; end
                else mb[3] <= 32'd3;
            end
        end
    end

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s inst%0d cyc %0d: got %h expected %h", name, g, cyc, act, exp);
        end
    endtask

    // Monitor: pops expectations when a DUT shows a write/done/error.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            for (int g = 0; g < 2; g++) begin
                ev_t e;
                if (we[g]) begin
                    if (exp_q[g].size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL unexpected_write inst%0d cyc %0d: got %h@%h expected none", g, cyc, wdata[g], addr[g]);
                    end else begin
                        e = exp_q[g].pop_front();
                        chk("wr_kind", g, 32'(0), 32'(e.kind));
                        chk("wr_addr", g, addr[g], e.addr);
                        chk("wr_data", g, wdata[g], e.data);
                        chk("wr_cycle", g, 32'(cyc), 32'(e.cyc));
                    end
                end else chk("data_zero_when_idle", g, wdata[g], 32'd0);
                if (done[g] || err[g]) begin
                    if (exp_q[g].size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL unexpected_end inst%0d cyc %0d: got done=%b error=%b expected none", g, cyc, done[g], err[g]);
                    end else begin
                        e = exp_q[g].pop_front();
                        chk("end_kind", g, 32'(done[g] ? 1 : 2), 32'(e.kind));
                        chk("end_both", g, 32'(done[g] & err[g]), 32'd0);
                        chk("result", g, res[g], e.data);
                        chk("end_cycle", g, 32'(cyc), 32'(e.cyc));
                    end
                end
                chk("busy", g, 32'(busy[g]), 32'(cyc >= busy_from && cyc < busy_to));
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Reference: a request accepted in cycle S writes at S+1..S+4, polls
    // from S+5; the flag seen on poll d (d < TO) ends with done at S+7+d,
    // otherwise error at S+5+TO. Start is honoured only after the previous
    // request's final cycle.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input int d, input logic [31:0] r, output int end_c);
        int s;
        s = cyc;
        end_c = last_end;
        if (s > last_end) begin
            cur_d = d; cur_res = r;
            end_c = (d < TO) ? s + 7 + d : s + 5 + TO;
            for (int g = 0; g < 2; g++) begin
                logic [31:0] bb;
                bb = (g == 0) ? BASE0 : BASE1;
                exp_q[g].push_back('{0, bb,          a,             s + 1});
                exp_q[g].push_back('{0, bb + 32'd4,  b,             s + 2});
                exp_q[g].push_back('{0, bb + 32'd8,  {28'd0, op},   s + 3});
                exp_q[g].push_back('{0, bb + 32'd12, 32'd1,         s + 4});
                exp_q[g].push_back('{0, bb + 32'd12, 32'd0,         end_c});
                exp_q[g].push_back('{(d < TO) ? 1 : 2, 32'd0, (d < TO) ? r : prev_res, end_c});
            end
            if (d < TO) prev_res = r;
            busy_from = s + 1; busy_to = end_c; last_end = end_c;
        end
        start = 1'b1; op_a = a; op_b = b; opcode = op;
        tick();
        start = 1'b0; op_a = $urandom; op_b = $urandom; opcode = 4'($urandom);
    endtask

    // Runs one request; optionally pulses a stray start at cycle spur.
    task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input int d, input logic [31:0] r, input int spur_off, input int idle);
        int e, spur, lim;
        issue(a, b, op, d, r, e);
        spur = (spur_off > 0) ? e - spur_off + 1 : -1;
        lim = cyc + 200;
        while (cyc <= e + idle && cyc < lim) begin
            start = (cyc == spur);
            op_a = $urandom; op_b = $urandom; opcode = 4'($urandom);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk({tag, "_busy"}, g, 32'(busy[g]), 32'd0);
            chk({tag, "_done"}, g, 32'(done[g]), 32'd0);
            chk({tag, "_error"}, g, 32'(err[g]), 32'd0);
            chk({tag, "_we"}, g, 32'(we[g]), 32'd0);
            chk({tag, "_result"}, g, res[g], 32'd0);
            chk({tag, "_data"}, g, wdata[g], 32'd0);
            chk({tag, "_addr"}, g, addr[g], 32'd0);
        end
    endtask

    initial begin
        int r;
        reset = 1'b1; start = 1'b0; op_a = 0; op_b = 0; opcode = 0;
        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();
        mon_en = 1;
        last_end = cyc - 1;

        // Directed: flag after 4 polls -> done 11 cycles after start.
        txn(32'd5, 32'd7, 4'h1, 4, 32'd12, 0, 1);
        // Flag already there on the first poll.
        txn($urandom, $urandom, 4'hA, 0, $urandom, 0, 0);
        // Never posted in time: timeout, result kept.
        txn($urandom, $urandom, 4'h3, 100, 32'hBAD0_BAD0, 0, 2);
        // Boundaries of the poll budget.
        txn($urandom, $urandom, 4'hF, TO - 1, $urandom, 0, 0);
        txn($urandom, $urandom, 4'h2, TO, $urandom, 0, 1);
        // Stray start during POLL, then in the CLR cycle itself.
        txn($urandom, $urandom, 4'h6, 5, $urandom, 3, 0);
        txn($urandom, $urandom, 4'h7, 2, $urandom, 1, 0);

        for (int i = 0; i < 30; i++) begin
            r = int'($urandom_range(0, 9));
            txn($urandom, $urandom, 4'($urandom),
                (r == 9) ? TO + int'($urandom_range(0, 5)) : int'($urandom_range(0, 8)),
                $urandom, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0,
                int'($urandom_range(0, 2)));
        end

        // Reset while polling: outputs clear, no flag write follows.
        begin
            int e;
            issue($urandom, $urandom, 4'h9, 12, $urandom, e);
            while (cyc < busy_from + 6) tick();
            reset = 1'b1;
            for (int g = 0; g < 2; g++) exp_q[g].delete();
            busy_to = cyc + 1; last_end = cyc; prev_res = 0;
            tick();
            reset = 1'b0;
            chk_zero("midreset");
        end
        repeat (3) tick();
        txn($urandom, $urandom, 4'h4, 3, $urandom, 0, 2);

        for (int g = 0; g < 2; g++) chk("leftover_events", g, 32'(exp_q[g].size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
